adc_capture_ctl: RTL
====================

Name: adc_capture_ctl

Overview:
- Reader-side counterpart to the key/DAC control block's parallel DAC writer: drives an 8-bit parallel pipelined ADC (TLC5510-class) and captures its samples.
- Generates the ADC clock and output-enable from SYSCLK and discards the converter's pipeline-latency samples after enable.
- Delivers each sample over a valid/ready handshake, plus a block average and running min/max for the board self-test display logic.

Parameters:
- CLK_DIV, 4, SYSCLK cycles per ADC_CLK period; even, >= 2.
- ADC_LATENCY, 3, ADC_CLK periods of converter pipeline delay discarded after start; 1..15.
- AVG_LOG2, 2, log2 of samples per average block; 0..4.

Ports:
- SYSCLK  input  1  system clock; the only clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  level; 1 = run the converter, 0 = stop.
- ADC_CLK  output  1  converter clock.
- ADC_OE_B  output  1  converter output enable, active low.
- ADC_DATA  input  8  converter parallel output bus.
- SAMPLE_DATA  output  8  latest captured sample.
- SAMPLE_VALID  output  1  SAMPLE_DATA holds an unconsumed sample.
- SAMPLE_READY  input  1  consumer accepts the sample when SAMPLE_VALID=1.
- AVG_DATA  output  8  mean of the last completed block.
- AVG_VALID  output  1  one-cycle pulse when AVG_DATA updates.
- PEAK_MAX  output  8  largest sample since the last clear.
- PEAK_MIN  output  8  smallest sample since the last clear.
- STAT_CLR  input  1  one-cycle pulse; clears peaks and OVERRUN.
- OVERRUN  output  1  sticky; a sample was overwritten before it was accepted.

Behaviour:
- Reset values: ADC_CLK=0, ADC_OE_B=1, SAMPLE_DATA=0, SAMPLE_VALID=0, AVG_DATA=0, AVG_VALID=0, PEAK_MAX=0x00, PEAK_MIN=0xFF, OVERRUN=0, state=IDLE, DIV_CNT=0, accumulator=0.
- All outputs are registered.
- States: IDLE, FILL, RUN.
  - IDLE -> FILL at the first edge with EN=1.
  - FILL -> RUN after ADC_LATENCY capture strobes.
  - FILL or RUN -> IDLE at any edge with EN=0.
- Clock divider:
  - DIV_CNT counts 0..CLK_DIV-1 and wraps; it runs only in FILL/RUN and is held at 0 in IDLE.
  - ADC_CLK=1 while DIV_CNT < CLK_DIV/2, else 0; it is forced to 0 in IDLE.
  - ADC_OE_B=0 in FILL/RUN, 1 in IDLE.
- Capture strobe: asserted in the cycle where DIV_CNT==CLK_DIV-1, i.e. the last low-phase cycle before the ADC_CLK rising edge. ADC_DATA is sampled on that cycle's closing edge.
- FILL: strobes are counted by a 4-bit latency counter. Data is discarded and no statistics are updated.
- RUN, on each strobe:
  - SAMPLE_DATA <= ADC_DATA and SAMPLE_VALID <= 1, visible one cycle after the strobe.
  - First valid sample, defaults: EN is sampled at edge 0; SAMPLE_VALID rises at edge 16 = (ADC_LATENCY+1)*CLK_DIV.
- Handshake:
  - A transfer occurs on an edge with SAMPLE_VALID && SAMPLE_READY. SAMPLE_VALID clears unless a strobe lands on the same edge.
  - Transfer and strobe on the same edge: the new sample loads, SAMPLE_VALID stays 1, OVERRUN is not set.
  - Strobe while SAMPLE_VALID=1 with no transfer: the new sample overwrites and OVERRUN <= 1.
- Average:
  - Accumulator width is 8+AVG_LOG2 bits and is fed by RUN strobes.
  - After the 2^AVG_LOG2-th sample: AVG_DATA <= (acc+sample) >> AVG_LOG2, truncated. AVG_VALID pulses for 1 cycle, aligned with that sample's SAMPLE_VALID update. The accumulator and sample count restart at 0.
- Peaks: each RUN sample updates PEAK_MAX=max(PEAK_MAX, s) and PEAK_MIN=min(PEAK_MIN, s).
- STAT_CLR:
  - Sets PEAK_MAX=0x00, PEAK_MIN=0xFF, OVERRUN=0.
  - Coincident with a strobe: PEAK_MAX=PEAK_MIN=that sample; OVERRUN takes the strobe's overrun result.
- EN drop (mid-FILL or mid-RUN): next edge enters IDLE. DIV_CNT, latency counter, accumulator and sample count are cleared, so a partial block is discarded.
  - SAMPLE_VALID, SAMPLE_DATA, AVG_DATA, peaks and OVERRUN are retained. A pending sample can still be accepted in IDLE.
- Re-enable always passes through FILL again.
- RST mid-operation: all registers return to their reset values immediately, asynchronously.

Test Plan:
- Reset, then EN=1 with ADC_DATA=0x5A constant, defaults -> ADC_CLK period 4 cycles with 50% duty, ADC_OE_B=0 one edge after EN; SAMPLE_VALID first rises at edge 16 with SAMPLE_DATA=0x5A.
- SAMPLE_READY=1, ADC_DATA=0x10,0x20,0x30,0x44 on successive strobes -> AVG_VALID pulses once with AVG_DATA=0x29 (0xA4>>2); OVERRUN stays 0.
- SAMPLE_READY=0 across two strobes -> OVERRUN=1, SAMPLE_DATA = second value. Then STAT_CLR -> OVERRUN=0, PEAK_MAX=0x00, PEAK_MIN=0xFF.
- Samples 0x80, 0x03, 0xFE -> PEAK_MAX=0xFE, PEAK_MIN=0x03. STAT_CLR on the same cycle as a strobe of 0x77 -> PEAK_MAX=PEAK_MIN=0x77.
- EN=0 after 2 samples of an average block -> IDLE next edge, ADC_CLK=0, ADC_OE_B=1, no AVG_VALID. Re-enable -> FILL discards 3 strobes; the next AVG_VALID requires 4 fresh samples.
- RST pulse while RUN with SAMPLE_VALID=1 -> all outputs at reset values without waiting for a SYSCLK edge.

Source files
------------

// File: rtl/adc_capture_ctl.sv
// Capture controller for an 8-bit pipelined parallel ADC: divided converter clock,
// pipeline-latency discard, valid/ready sample delivery, block average and peaks.
module adc_capture_ctl #(
    parameter int CLK_DIV     = 4,
    parameter int ADC_LATENCY = 3,
    parameter int AVG_LOG2    = 2
) (
    input  logic       i_sysclk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_adc_clk,
    output logic       o_adc_oe_b,
    input  logic [7:0] i_adc_data,
    output logic [7:0] o_sample_data,
    output logic       o_sample_valid,
    input  logic       i_sample_ready,
    output logic [7:0] o_avg_data,
    output logic       o_avg_valid,
    output logic [7:0] o_peak_max,
    output logic [7:0] o_peak_min,
    input  logic       i_stat_clr,
    output logic       o_overrun
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int NS = 1 << AVG_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_div_cnt;
    logic [DW-1:0]   w_div_next;
    logic [3:0]      r_lat_cnt;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   w_sum;
    logic            w_strobe;
    logic            w_run_strobe;
    logic            w_xfer;
    logic            w_ovr_hit;
    logic            w_block_done;

    assign w_strobe     = (r_state != S_IDLE) && (r_div_cnt == DW'(CLK_DIV - 1));
    // A strobe on the same edge as an EN drop is ignored so the partial block clears cleanly.
    assign w_run_strobe = (r_state == S_RUN) && w_strobe && i_en;
    assign w_xfer       = o_sample_valid && i_sample_ready;
    assign w_ovr_hit    = w_run_strobe && o_sample_valid && !i_sample_ready;
    assign w_sum        = r_acc + AW'(i_adc_data);
    assign w_block_done = (r_cnt == CW'(NS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_en) w_state_next = S_FILL;
            S_FILL: begin
                if (!i_en)
                    w_state_next = S_IDLE;
                else if (w_strobe && (r_lat_cnt == 4'(ADC_LATENCY - 1)))
                    w_state_next = S_RUN;
            end
            S_RUN:  if (!i_en) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_div_next = '0;
        if (r_state != S_IDLE && w_state_next != S_IDLE && !w_strobe)
            w_div_next = r_div_cnt + 1'b1;
    end

    // Converter clock/enable are registered from next-state values so they track DIV_CNT exactly.
    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_lat_cnt  <= '0;
            o_adc_clk  <= 1'b0;
            o_adc_oe_b <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_div_cnt  <= w_div_next;
            o_adc_clk  <= (w_state_next != S_IDLE) && (w_div_next < DW'(CLK_DIV / 2));
            o_adc_oe_b <= (w_state_next == S_IDLE);
            if (!i_en || r_state != S_FILL)
                r_lat_cnt <= '0;
            else if (w_strobe)
                r_lat_cnt <= r_lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            o_sample_data  <= '0;
            o_sample_valid <= 1'b0;
            o_avg_data     <= '0;
            o_avg_valid    <= 1'b0;
            o_peak_max     <= 8'h00;
            o_peak_min     <= 8'hFF;
            o_overrun      <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
        end else begin
            o_avg_valid <= 1'b0;

            if (w_run_strobe) begin
                o_sample_data  <= i_adc_data;
                o_sample_valid <= 1'b1;
            end else if (w_xfer) begin
                o_sample_valid <= 1'b0;
            end

            if (i_stat_clr)
                o_overrun <= w_ovr_hit;
            else if (w_ovr_hit)
                o_overrun <= 1'b1;

            if (i_stat_clr) begin
                o_peak_max <= w_run_strobe ? i_adc_data : 8'h00;
                o_peak_min <= w_run_strobe ? i_adc_data : 8'hFF;
            end else if (w_run_strobe) begin
                if (i_adc_data > o_peak_max) o_peak_max <= i_adc_data;
                if (i_adc_data < o_peak_min) o_peak_min <= i_adc_data;
            end

            if (!i_en) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_run_strobe) begin
                if (w_block_done) begin
                    o_avg_data  <= w_sum[AW-1:AVG_LOG2];
                    o_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
